// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial instruction fetch that assembles 1/2-byte big-endian instructions
// and holds them for execute. Define IFETCH_TIMEOUT_EN to enable the ack-timeout FAULT state.
module fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic [1:0]  inst_bytes,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic        fault
);

`ifdef IFETCH_TIMEOUT_EN
  typedef enum logic [2:0] {HI, LO, VALID, HALT, FAULT} state_t;
`else
  typedef enum logic [1:0] {HI, LO, VALID, HALT} state_t;
`endif

  state_t      state, state_n;
  logic [15:0] pc, pc_n, addr_n, inst_n, inst_pc_n;
  logic [1:0]  bytes_n;
  logic        accept, consume, timeout;

  // An ack only counts while a request is actually outstanding.
  assign accept  = mem_req & mem_ack;
  assign consume = (state == VALID) & inst_ready;

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout = mem_req & ~mem_ack & (wait_cnt == TIMEOUT_CYCLES - 8'd1);

  always_ff @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + 8'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= HI;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      HI: begin
        if (accept)       state_n = mem_rdata[7] ? LO : VALID;
`ifdef IFETCH_TIMEOUT_EN
        else if (timeout) state_n = FAULT;
`endif
      end
      LO: begin
        if (accept)       state_n = VALID;
`ifdef IFETCH_TIMEOUT_EN
        else if (timeout) state_n = FAULT;
`endif
      end
      VALID:   if (consume) state_n = halt ? HALT : HI;
      default: state_n = state;
    endcase
  end

  always_comb begin
    pc_n      = pc;
    addr_n    = mem_addr;
    inst_n    = inst;
    bytes_n   = inst_bytes;
    inst_pc_n = inst_pc;
    case (state)
      HI: if (accept) begin
        inst_n    = {mem_rdata, 8'h00};
        bytes_n   = mem_rdata[7] ? 2'd2 : 2'd1;
        inst_pc_n = pc;
        if (mem_rdata[7]) addr_n = pc + 16'd1;
      end
      LO: if (accept) inst_n[7:0] = mem_rdata;
      VALID: if (consume && !halt) begin
        pc_n   = redirect ? redirect_pc : pc + {14'd0, inst_bytes};
        addr_n = pc_n;
      end
      default: ;
    endcase
  end

  // Outputs are registered from the next state so a new request is visible the cycle after consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      mem_addr   <= RESET_PC;
      mem_req    <= 1'b0;
      inst       <= '0;
      inst_valid <= 1'b0;
      inst_bytes <= 2'd1;
      inst_pc    <= '0;
      halted     <= 1'b0;
    end else begin
      pc         <= pc_n;
      mem_addr   <= addr_n;
      mem_req    <= (state_n == HI) || (state_n == LO);
      inst       <= inst_n;
      inst_valid <= (state_n == VALID);
      inst_bytes <= bytes_n;
      inst_pc    <= inst_pc_n;
      halted     <= (state_n == HALT);
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) fault <= 1'b0;
    else     fault <= (state_n == FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule
